// File: rtl/bitty_fetch_if.sv
// bitty_fetch_if: instruction memory read port plus run/instruction/done handshake to the core
interface bitty_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic               run;
  logic [INSTR_W-1:0] instruction;
  logic               done;
  modport master (output mem_rd, mem_addr, run, instruction, input mem_rdata, done);
  modport slave  (input mem_rd, mem_addr, run, instruction, output mem_rdata, done);
endinterface

// File: rtl/bitty_fetch_unit.sv
// bitty_fetch_unit: fetches instructions over an address range and issues them to the core one at a time
module bitty_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  bitty_fetch_if.master     bus,
  output logic              busy,
  output logic              finished,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, ISSUE, EXEC, NEXT} state_t;
  state_t             state;
  logic [ADDR_W-1:0]  end_q;
  logic [INSTR_W-1:0] instr_q;
  logic               stop_pending;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pc           <= '0;
      end_q        <= '0;
      instr_q      <= '0;
      instr_count  <= '0;
      stop_pending <= 1'b0;
    end else begin
      if (state != IDLE && stop) stop_pending <= 1'b1;
      case (state)
        IDLE: if (start) begin
          pc           <= start_addr;
          end_q        <= end_addr;
          instr_count  <= '0;
          stop_pending <= 1'b0;
          state        <= FETCH;
        end
        FETCH: state <= WAIT_MEM;
        WAIT_MEM: begin
          instr_q <= bus.mem_rdata;
          state   <= ISSUE;
        end
        ISSUE: state <= EXEC;
        EXEC: if (bus.done) begin
          instr_count <= instr_count + {15'd0, ~&instr_count};
          state       <= NEXT;
        end
        NEXT: if (stop_pending || pc == end_q) state <= IDLE;
        else begin
          pc    <= pc + 1'b1;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.mem_rd      = state == FETCH;
  assign bus.mem_addr    = pc;
  assign bus.run         = state == ISSUE;
  assign bus.instruction = instr_q;
  assign busy            = state != IDLE;
  assign finished        = state == NEXT && (stop_pending || pc == end_q);
endmodule

// File: tb/tb_bitty_fetch_unit.sv
// tb_bitty_fetch_unit: random programs checked by a scoreboard fed from a queue-based reference model
module tb_bitty_fetch_unit;
  logic        clk = 0, reset = 1, start = 0, main_stop = 0, core_stop = 0, stop;
  logic        core_done = 0, idle_done = 0, busy, finished;
  logic [7:0]  start_addr = 0, end_addr = 0, pc;
  logic [15:0] instr_count;
  logic [15:0] mem [256];
  int          total = 0, bad = 0, cyc = 0, nf_cyc = -1, fin_cyc = -1, run_cyc = -1;
  int          nrun = 0, stop_at = 0, fix_lat = -1;
  bit          core_en = 1;
  logic [7:0]  exp_fetch [$];
  logic [23:0] exp_run [$];
  logic [15:0] exp_fin [$];

  bitty_fetch_if #(.ADDR_W(8), .INSTR_W(16)) bus ();
  bitty_fetch_unit #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .bus(bus),
    .busy(busy), .finished(finished), .pc(pc), .instr_count(instr_count)
  );

  assign stop     = main_stop | core_stop;
  assign bus.done = core_done | idle_done;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : 16'($urandom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic oops(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT produced an event, required none", name);
  endtask

  // scoreboard monitor: pops the reference expectations whenever the DUT presents an event
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.mem_rd) begin
          if (exp_fetch.size() == 0) oops("fetch");
          else begin
            chk("fetch_addr", bus.mem_addr, exp_fetch.pop_front());
            chk("fetch_cycle", cyc, nf_cyc);
          end
          run_cyc = cyc + 2;
        end
        if (bus.run) begin
          if (exp_run.size() == 0) oops("run");
          else begin
            e = exp_run.pop_front();
            chk("run_pc", pc, e[23:16]);
            chk("run_instr", bus.instruction, e[15:0]);
            chk("run_cycle", cyc, run_cyc);
          end
        end
        if (finished) begin
          if (exp_fin.size() == 0) oops("finished");
          else begin
            chk("fin_count", instr_count, exp_fin.pop_front());
            chk("fin_cycle", cyc, fin_cyc);
            chk("fin_busy", busy, 1);
          end
        end
      end
    end
  end

  // core model: random execution time, random hold of done, occasional done during ISSUE
  initial begin
    int lat, hold;
    forever begin
      @(negedge clk);
      if (reset && core_en && bus.run) begin
        nrun++;
        lat  = fix_lat >= 0 ? fix_lat : int'($urandom_range(3));
        hold = int'($urandom_range(4, 1));
        if ($urandom_range(1) == 1) core_done = 1;
        @(posedge clk);
        #1 core_done = 0;
        if (nrun == stop_at) core_stop = 1;
        repeat (lat) begin
          @(posedge clk);
          #1 core_stop = 0;
        end
        core_done = 1;
        nf_cyc    = cyc + 2;
        fin_cyc   = cyc + 1;
        repeat (hold) begin
          @(posedge clk);
          #1 core_stop = 0;
        end
        core_done = 0;
      end
    end
  end

  task automatic wait_fin(input string name);
    int i;
    i = 0;
    while (exp_fin.size() != 0 && i < 3000) begin
      @(posedge clk);
      i++;
    end
    if (exp_fin.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: timeout with %0d finish pending, required 0", name, exp_fin.size());
      exp_fin.delete();
      exp_run.delete();
      exp_fetch.delete();
    end
  endtask

  task automatic run_prog(input logic [7:0] sa, input logic [7:0] ea, input int stop_n, input bit with_stop);
    logic [7:0]  a;
    logic [15:0] last;
    int          n;
    a = sa;
    n = 0;
    forever begin
      exp_fetch.push_back(a);
      exp_run.push_back({a, mem[a]});
      n++;
      if (n == stop_n || a == ea) break;
      a = a + 8'd1;
    end
    exp_fin.push_back(16'(n));
    last    = mem[a];
    nrun    = 0;
    stop_at = stop_n;
    @(posedge clk);
    #1 start = 1;
    start_addr = sa;
    end_addr   = ea;
    main_stop  = with_stop;
    nf_cyc     = cyc + 1;
    @(posedge clk);
    #1 start = 0;
    main_stop  = 0;
    start_addr = 8'($urandom);
    end_addr   = 8'($urandom);
    if (n >= 2) begin
      repeat (4) @(posedge clk);
      #1 start = 1;
      @(posedge clk);
      #1 start = 0;
    end
    wait_fin("program_end");
    @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("held_instr", bus.instruction, last);
    chk("left_runs", exp_run.size(), 0);
    chk("left_fetches", exp_fetch.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sa;
    int len;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[8'h20] = 16'hBEEF;
    #2 reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_run", bus.run, 0);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_finished", finished, 0);
    chk("rst_pc", pc, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_instr", bus.instruction, 0);
    reset = 1;
    fix_lat = 2;
    run_prog(8'h00, 8'h02, 0, 0);
    chk("basic_count", instr_count, 3);
    fix_lat = -1;
    run_prog(8'hFE, 8'h01, 0, 0);
    chk("wrap_count", instr_count, 4);
    run_prog(8'h40, 8'h44, 2, 0);
    chk("stop_count", instr_count, 2);
    run_prog(8'h10, 8'h10, 0, 1);
    chk("single_count", instr_count, 1);
    idle_done = 1;
    repeat (3) @(posedge clk);
    #1 idle_done = 0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_count", instr_count, 1);
    core_en = 0;
    exp_fetch.push_back(8'h20);
    exp_run.push_back({8'h20, mem[8'h20]});
    @(posedge clk);
    #1 start = 1;
    start_addr = 8'h20;
    end_addr   = 8'h30;
    nf_cyc     = cyc + 1;
    @(posedge clk);
    #1 start = 0;
    repeat (6) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("mid_rst_run", bus.run, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_instr", bus.instruction, 0);
    chk("mid_rst_finished", finished, 0);
    chk("mid_rst_count", instr_count, 0);
    @(posedge clk);
    #1 reset = 1;
    core_en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_runs", exp_run.size(), 0);
    for (int t = 0; t < 10; t++) begin
      sa  = 8'($urandom);
      len = int'($urandom_range(6, 1));
      run_prog(sa, sa + 8'(len - 1), int'($urandom_range(len, 0)), 1'($urandom_range(1)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
